// File: rtl/audio_clk_pkg.sv
// Shared definitions for the audio clock-enable generator.
//   - mode_t           : channel operating mode (integer divide / NCO)
//   - DEFAULT_ACC_W    : default divisor / accumulator width
//   - CH0_RESET_DIV    : channel 0 power-up divisor (PSG tick, divide-by-16)
//   - CHN_RESET_INC    : power-up NCO increment of all other channels (silent)
//   - reset_mode/value : per-channel power-up settings, indexed by channel
package audio_clk_pkg;

    typedef enum logic {
        MODE_INT = 1'b0,
        MODE_NCO = 1'b1
    } mode_t;

    localparam int DEFAULT_ACC_W = 24;
    localparam int unsigned CH0_RESET_DIV = 32'd15;
    localparam int unsigned CHN_RESET_INC = 32'd0;

    function automatic mode_t reset_mode(input int ch);
        if (ch == 0) begin
            return MODE_INT;
        end else begin
            return MODE_NCO;
        end
    endfunction

    function automatic int unsigned reset_value(input int ch);
        if (ch == 0) begin
            return CH0_RESET_DIV;
        end else begin
            return CHN_RESET_INC;
        end
    endfunction

endpackage

// File: rtl/audio_clk_en_channel.sv
// One clock-enable channel: live and shadow settings, pending flag, phase
// counter and registered enable output.
//   clk, reset     : clock and synchronous active-high reset
//   run            : low clears phase and output, and applies any pending write
//   wr             : this channel is the target of a configuration write
//   wr_mode/value  : configuration data captured into the shadow set
//   pending        : a shadow setting is waiting for its period boundary
//   en             : one-cycle enable pulses
module audio_clk_en_channel
    import audio_clk_pkg::*;
#(
    parameter int          ACC_W       = DEFAULT_ACC_W,
    parameter mode_t       RESET_MODE  = MODE_INT,
    parameter int unsigned RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             wr,
    input  logic             wr_mode,
    input  logic [ACC_W-1:0] wr_value,
    output logic             pending,
    output logic             en
);

    mode_t            live_mode_r;
    mode_t            sh_mode_r;
    logic [ACC_W-1:0] live_value_r;
    logic [ACC_W-1:0] sh_value_r;
    logic [ACC_W-1:0] cnt_r;
    logic             pending_r;
    logic             en_r;

    logic [ACC_W:0]   nco_sum_s;
    logic [ACC_W-1:0] cnt_adv_s;
    logic             en_adv_s;
    logic             stalled_s;
    logic             apply_s;

    // Next phase and enable for the live mode, plus the shadow-apply decision.
    always_comb begin
        nco_sum_s = {1'b0, cnt_r} + {1'b0, live_value_r};
        cnt_adv_s = cnt_r;
        en_adv_s  = 1'b0;
        case (live_mode_r)
            MODE_INT: begin
                if (cnt_r == live_value_r) begin
                    cnt_adv_s = '0;
                    en_adv_s  = 1'b1;
                end else begin
                    cnt_adv_s = cnt_r + {{(ACC_W-1){1'b0}}, 1'b1};
                    en_adv_s  = 1'b0;
                end
            end
            MODE_NCO: begin
                cnt_adv_s = nco_sum_s[ACC_W-1:0];
                en_adv_s  = nco_sum_s[ACC_W];
            end
            default: begin
                cnt_adv_s = cnt_r;
                en_adv_s  = 1'b0;
            end
        endcase
        // A zero-increment NCO never reaches a boundary, so it accepts writes at once.
        stalled_s = (live_mode_r == MODE_NCO) && (live_value_r == '0);
        apply_s   = pending_r && (!run || en_adv_s || stalled_s);
    end

    // Channel state: settings, pending flag, phase counter and enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_mode_r  <= RESET_MODE;
            sh_mode_r    <= RESET_MODE;
            live_value_r <= ACC_W'(RESET_VALUE);
            sh_value_r   <= ACC_W'(RESET_VALUE);
            cnt_r        <= '0;
            pending_r    <= 1'b0;
            en_r         <= 1'b0;
        end else begin
            // Apply reads the old shadow; a same-edge write lands after it.
            if (apply_s) begin
                live_mode_r  <= sh_mode_r;
                live_value_r <= sh_value_r;
            end
            if (wr) begin
                sh_mode_r  <= mode_t'(wr_mode);
                sh_value_r <= wr_value;
                pending_r  <= 1'b1;
            end else if (apply_s) begin
                pending_r <= 1'b0;
            end
            if (!run) begin
                cnt_r <= '0;
                en_r  <= 1'b0;
            end else begin
                en_r <= en_adv_s;
                if (apply_s && (sh_mode_r != live_mode_r)) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_adv_s;
                end
            end
        end
    end

    assign pending = pending_r;
    assign en      = en_r;

endmodule

// File: rtl/audio_clk_en_gen.sv
// Multi-channel audio clock-enable generator. Decodes configuration writes
// to one of CHANNELS independent divider / NCO channels.
//   clk_peripheral : sole clock
//   reset          : synchronous active-high reset
//   run            : global run; low stops and phase-clears every channel
//   cfg_we/ch      : write strobe and target channel (out-of-range ignored)
//   cfg_mode/value : 0 = integer divisor D, 1 = NCO increment
//   cfg_pending    : per-channel write waiting for its boundary
//   en             : per-channel registered enable pulses
module audio_clk_en_gen
    import audio_clk_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int ACC_W    = DEFAULT_ACC_W,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_peripheral,
    input  logic                reset,
    input  logic                run,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic                cfg_mode,
    input  logic [ACC_W-1:0]    cfg_value,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] en
);

    logic [CHANNELS-1:0] wr_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Only existing channel indices decode, so out-of-range writes are dropped.
        assign wr_s[i] = cfg_we && (cfg_ch == CH_W'(i));

        audio_clk_en_channel #(
            .ACC_W       (ACC_W),
            .RESET_MODE  (reset_mode(i)),
            .RESET_VALUE (reset_value(i))
        ) u_ch (
            .clk      (clk_peripheral),
            .reset    (reset),
            .run      (run),
            .wr       (wr_s[i]),
            .wr_mode  (cfg_mode),
            .wr_value (cfg_value),
            .pending  (cfg_pending[i]),
            .en       (en[i])
        );
    end

endmodule

// File: tb/tb_audio_clk_en_gen.sv
module tb_audio_clk_en_gen;

    logic        clk_peripheral = 1'b0;
    logic        reset;
    logic        run;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_mode;
    logic [23:0] cfg_value;
    logic [3:0]  cfg_pending;
    logic [3:0]  en;

    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [2:0]  cfg_pending3;
    logic [2:0]  en3;

    int checks   = 0;
    int failures = 0;
    int pulses;
    int bad;

    always #5 clk_peripheral = ~clk_peripheral;

    audio_clk_en_gen #(.CHANNELS(4), .ACC_W(24)) dut (
        .clk_peripheral (clk_peripheral),
        .reset          (reset),
        .run            (run),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_mode       (cfg_mode),
        .cfg_value      (cfg_value),
        .cfg_pending    (cfg_pending),
        .en             (en)
    );

    // Non-power-of-two instance, so an out-of-range channel index is representable.
    audio_clk_en_gen #(.CHANNELS(3), .ACC_W(24)) dut3 (
        .clk_peripheral (clk_peripheral),
        .reset          (reset),
        .run            (run),
        .cfg_we         (cfg_we3),
        .cfg_ch         (cfg_ch3),
        .cfg_mode       (cfg_mode),
        .cfg_value      (cfg_value),
        .cfg_pending    (cfg_pending3),
        .en             (en3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_peripheral);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input logic mode, input logic [23:0] value);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_value = value;
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = 2'd0;
        cfg_mode  = 1'b0;
        cfg_value = 24'd0;
        cfg_we3   = 1'b0;
        cfg_ch3   = 2'd0;
        step();
        step();
        chk("reset_en", 32'(en), 32'h0);
        chk("reset_pending", 32'(cfg_pending), 32'h0);
        chk("reset_en3", 32'(en3), 32'h0);

        // Default configuration: ch0 divide-by-16, others silent.
        reset = 1'b0;
        run   = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("ch0_default", 32'(en[0]), 32'((k % 16) == 0));
            chk("ch_silent", 32'(en[3:1]), 32'h0);
        end

        // ch1 integer D=2 (stalled NCO, so it applies on the next edge).
        wr_cfg(2'd1, 1'b0, 24'd2);
        step();
        cfg_we = 1'b0;
        chk("ch1_pend_set", 32'(cfg_pending[1]), 32'h1);
        step();
        chk("ch1_pend_clr", 32'(cfg_pending[1]), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("ch1_div3", 32'(en[1]), 32'((k % 3) == 0));
        end

        // ch1 D=0: applies on the next pulse, then en stays high.
        wr_cfg(2'd1, 1'b0, 24'd0);
        step();
        cfg_we = 1'b0;
        chk("ch1_d0_pend_a", 32'(cfg_pending[1]), 32'h1);
        chk("ch1_d0_en_a", 32'(en[1]), 32'h0);
        step();
        chk("ch1_d0_pend_b", 32'(cfg_pending[1]), 32'h1);
        chk("ch1_d0_en_b", 32'(en[1]), 32'h0);
        step();
        chk("ch1_d0_pend_c", 32'(cfg_pending[1]), 32'h0);
        chk("ch1_d0_en_c", 32'(en[1]), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("ch1_d0_hold", 32'(en[1]), 32'h1);
        end

        // ch2 NCO increment 0x400000: one pulse per 4 cycles.
        wr_cfg(2'd2, 1'b1, 24'h400000);
        step();
        cfg_we = 1'b0;
        chk("ch2_pend_set", 32'(cfg_pending[2]), 32'h1);
        step();
        chk("ch2_pend_clr", 32'(cfg_pending[2]), 32'h0);
        pulses = 0;
        bad    = 0;
        for (int j = 1; j <= 1000; j++) begin
            step();
            if (en[2] === 1'b1) pulses++;
            if (en[2] !== ((j % 4) == 0)) bad++;
        end
        chk("nco_count", 32'(pulses), 32'd250);
        chk("nco_pattern", 32'(bad), 32'd0);

        // Re-align phases, then write ch0 D=3 at cnt=5.
        run = 1'b0;
        step();
        chk("run_low_en", 32'(en), 32'h0);
        run = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        wr_cfg(2'd0, 1'b0, 24'd3);
        step();
        cfg_we = 1'b0;
        chk("ch0_mid_pend", 32'(cfg_pending[0]), 32'h1);
        chk("ch0_mid_en6", 32'(en[0]), 32'h0);
        for (int k = 7; k <= 28; k++) begin
            step();
            chk("ch0_retune_en", 32'(en[0]), 32'((k == 16) || (k > 16 && ((k - 16) % 4) == 0)));
            chk("ch0_retune_pend", 32'(cfg_pending[0]), 32'(k < 16));
        end

        // ch1 to D=9, then D=5 and D=7 before the boundary: last write wins.
        wr_cfg(2'd1, 1'b0, 24'd9);
        step();
        cfg_we = 1'b0;
        step();
        chk("ch1_d9_apply_en", 32'(en[1]), 32'h1);
        chk("ch1_d9_apply_pend", 32'(cfg_pending[1]), 32'h0);
        wr_cfg(2'd1, 1'b0, 24'd5);
        step();
        wr_cfg(2'd1, 1'b0, 24'd7);
        step();
        cfg_we = 1'b0;
        chk("ch1_lww_pend", 32'(cfg_pending[1]), 32'h1);
        for (int k = 3; k <= 26; k++) begin
            step();
            chk("ch1_lww_en", 32'(en[1]), 32'((k == 10) || (k == 18) || (k == 26)));
            chk("ch1_lww_pend_k", 32'(cfg_pending[1]), 32'(k < 10));
        end

        // Run low: outputs zero, pending write applies; restart is phase-aligned.
        run = 1'b0;
        step();
        chk("stop_en_a", 32'(en), 32'h0);
        wr_cfg(2'd1, 1'b0, 24'd3);
        step();
        cfg_we = 1'b0;
        chk("stop_pend_set", 32'(cfg_pending[1]), 32'h1);
        chk("stop_en_b", 32'(en), 32'h0);
        step();
        chk("stop_pend_clr", 32'(cfg_pending[1]), 32'h0);
        chk("stop_en_c", 32'(en), 32'h0);
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("restart_align", 32'(en), ((k % 4) == 0) ? 32'h7 : 32'h0);
        end

        // Reset mid-period with a write pending.
        wr_cfg(2'd0, 1'b0, 24'd5);
        step();
        cfg_we = 1'b0;
        chk("pre_reset_pend", 32'(cfg_pending[0]), 32'h1);
        reset = 1'b1;
        step();
        chk("mid_reset_en", 32'(en), 32'h0);
        chk("mid_reset_pend", 32'(cfg_pending), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("post_reset_en", 32'(en), (k == 16) ? 32'h1 : 32'h0);
        end

        // Out-of-range channel on a 3-channel instance is ignored.
        cfg_we3   = 1'b1;
        cfg_ch3   = 2'd3;
        cfg_mode  = 1'b0;
        cfg_value = 24'd2;
        step();
        cfg_we3 = 1'b0;
        chk("oor_ch_ignored", 32'(cfg_pending3), 32'h0);
        cfg_we3 = 1'b1;
        cfg_ch3 = 2'd2;
        step();
        cfg_we3 = 1'b0;
        chk("inrange_ch_pend", 32'(cfg_pending3), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
